// File: rtl/f2c_arb_pkg.sv
// f2c_arb_pkg: types for the FPGA-to-CPU stream arbiter.
//   ArbState  : arbiter FSM state (IDLE, GRANT0, GRANT1).
//   BeatCount : widest in-burst beat counter (BURST_LEN up to 256).
package f2c_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } ArbState;

  localparam int unsigned BEAT_CNT_MAX_W = 8;

  typedef logic [BEAT_CNT_MAX_W-1:0] BeatCount;

endpackage

// File: rtl/tlp_xcvr_pkg.sv
// tlp_xcvr_pkg: shared types for the TLP transceiver datapath.
//   uint64 : 64-bit payload word used on DMA streams.
package tlp_xcvr_pkg;

  typedef logic [63:0] uint64;

endpackage

// File: rtl/f2c_arb_pick.sv
// f2c_arb_pick: combinational round-robin next-grant selection.
//   req        : per-source request (valid AND enable)
//   last_grant : source granted most recently (1 = source 1)
//   pick       : GRANT0/GRANT1 for the chosen source, IDLE when no request
import f2c_arb_pkg::*;

module f2c_arb_pick (
  input  logic [1:0] req,
  input  logic       last_grant,
  output ArbState    pick
);

  always_comb begin
    pick = IDLE;
    case (req)
      2'b01:   pick = GRANT0;
      2'b10:   pick = GRANT1;
      2'b11:   pick = last_grant ? GRANT0 : GRANT1;
      default: pick = IDLE;
    endcase
  end

endmodule

// File: rtl/f2c_arb.sv
// f2c_arb: two-source burst arbiter merging onto the f2c DMA stream.
// A grant holds for BURST_LEN accepted beats (valid & ready); the next
// grant is chosen round-robin in the cycle of the final beat.
// Optional build macro F2C_ARB_STATS_EN enables 32-bit per-source beat
// counters; without it srcNBeats_out are tied to zero.
// Ports:
//   pcieClk_in, reset_in       : clock, synchronous active-high reset
//   srcEnable_in[1:0]          : per-source request enable
//   srcN{Data,Valid}_in        : source payload / valid
//   srcNReady_out              : source ready
//   f2cData_out/f2cValid_out   : merged stream; f2cReady_in from DMA
//   grant_out[1:0]             : one-hot current grant, 00 when idle
//   srcNBeats_out[31:0]        : per-source accepted beat counters
import f2c_arb_pkg::*;
import tlp_xcvr_pkg::*;

module f2c_arb #(
  parameter int unsigned BURST_LEN = 16
) (
  input  logic        pcieClk_in,
  input  logic        reset_in,
  input  logic [1:0]  srcEnable_in,
  input  uint64       src0Data_in,
  input  logic        src0Valid_in,
  output logic        src0Ready_out,
  input  uint64       src1Data_in,
  input  logic        src1Valid_in,
  output logic        src1Ready_out,
  output uint64       f2cData_out,
  output logic        f2cValid_out,
  input  logic        f2cReady_in,
  output logic [1:0]  grant_out,
  output logic [31:0] src0Beats_out,
  output logic [31:0] src1Beats_out
);

  localparam int unsigned CNT_W = $clog2(BURST_LEN);
  localparam BeatCount LAST_BEAT = BeatCount'(BURST_LEN - 1);

  ArbState          state, state_next, pick;
  logic [CNT_W-1:0] beat_cnt;
  logic             last_grant;
  logic             beat, final_beat, grant_entry;
  logic [1:0]       req;

  assign req = {src1Valid_in & srcEnable_in[1], src0Valid_in & srcEnable_in[0]};

  f2c_arb_pick u_pick (
    .req        (req),
    .last_grant (last_grant),
    .pick       (pick)
  );

  // Routing is combinational; reset forces the handshake signals low so no
  // beat can be accepted during the reset cycle.
  always_comb begin
    f2cData_out   = '0;
    f2cValid_out  = 1'b0;
    src0Ready_out = 1'b0;
    src1Ready_out = 1'b0;
    case (state)
      GRANT0: begin
        f2cData_out   = src0Data_in;
        f2cValid_out  = src0Valid_in;
        src0Ready_out = f2cReady_in;
      end
      GRANT1: begin
        f2cData_out   = src1Data_in;
        f2cValid_out  = src1Valid_in;
        src1Ready_out = f2cReady_in;
      end
      default: ;
    endcase
    if (reset_in) begin
      f2cValid_out  = 1'b0;
      src0Ready_out = 1'b0;
      src1Ready_out = 1'b0;
    end
  end

  assign beat       = f2cValid_out & f2cReady_in;
  assign final_beat = beat && (beat_cnt == LAST_BEAT[CNT_W-1:0]);
  assign grant_out  = {state == GRANT1, state == GRANT0};

  always_comb begin
    state_next = state;
    case (state)
      IDLE:           state_next = pick;
      GRANT0, GRANT1: if (final_beat) state_next = pick;
      default:        state_next = IDLE;
    endcase
  end

  assign grant_entry = (state_next != IDLE) && ((state == IDLE) || final_beat);

  always_ff @(posedge pcieClk_in) begin
    if (reset_in) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      last_grant <= 1'b1;
    end else begin
      state <= state_next;
      if (grant_entry) begin
        beat_cnt   <= '0;
        last_grant <= (state_next == GRANT1);
      end else if (beat) begin
        // Power-of-two burst length: the final beat wraps the counter to 0.
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

`ifdef F2C_ARB_STATS_EN
  logic [31:0] beats0, beats1;

  always_ff @(posedge pcieClk_in) begin
    if (reset_in) begin
      beats0 <= '0;
      beats1 <= '0;
    end else begin
      if (beat && state == GRANT0) beats0 <= beats0 + 32'd1;
      if (beat && state == GRANT1) beats1 <= beats1 + 32'd1;
    end
  end

  assign src0Beats_out = beats0;
  assign src1Beats_out = beats1;
`else
  assign src0Beats_out = '0;
  assign src1Beats_out = '0;
`endif

endmodule

// File: tb/tb_f2c_arb.sv
// tb_f2c_arb: self-checking bench for f2c_arb with BURST_LEN=4.
// Per-cycle vector table (inputs + expected grant/handshake) plus a data
// scoreboard: the expected payload is queued when a beat is expected and
// popped when the DUT shows valid & ready.
import tlp_xcvr_pkg::*;

module tb_f2c_arb;

`ifdef F2C_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [1:0]  en;
  uint64       d0, d1, dout;
  logic        v0, v1, r0, r1;
  logic        valid, rdy;
  logic [1:0]  grant;
  logic [31:0] b0, b1;

  f2c_arb #(.BURST_LEN(4)) dut (
    .pcieClk_in    (clk),
    .reset_in      (reset),
    .srcEnable_in  (en),
    .src0Data_in   (d0),
    .src0Valid_in  (v0),
    .src0Ready_out (r0),
    .src1Data_in   (d1),
    .src1Valid_in  (v1),
    .src1Ready_out (r1),
    .f2cData_out   (dout),
    .f2cValid_out  (valid),
    .f2cReady_in   (rdy),
    .grant_out     (grant),
    .src0Beats_out (b0),
    .src1Beats_out (b1)
  );

  always #4 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] en;
    logic       v0, v1, rdy;
    logic [1:0] eg;
    logic       ev, er0, er1;
  } vec_t;

  vec_t  vecs[$];
  uint64 sb[$];
  int    errors = 0;
  int    checks = 0;
  int    eb0 = 0;
  int    eb1 = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void add(input logic rst, input logic [1:0] e, input logic a0, input logic a1,
                              input logic rd, input logic [1:0] g, input logic ev,
                              input logic x0, input logic x1);
    vec_t v;
    v.rst = rst; v.en = e; v.v0 = a0; v.v1 = a1; v.rdy = rd;
    v.eg = g; v.ev = ev; v.er0 = x0; v.er1 = x1;
    vecs.push_back(v);
  endfunction

  initial begin
    clk = 1'b0; reset = 1'b1; en = 2'b00; v0 = 1'b0; v1 = 1'b0; rdy = 1'b0;
    d0 = '0; d1 = '0;

    // Only src0: regrant with no bubble, then reset while granted.
    add(0, 2'b11, 1, 0, 1, 2'b00, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 2'b11, 1, 0, 1, 2'b01, 1, 1, 0);
    add(1, 2'b11, 1, 0, 1, 2'b01, 0, 0, 0);
    // Both valid: 4x src0, 4x src1, 4x src0.
    add(0, 2'b11, 1, 1, 1, 2'b00, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 2'b11, 1, 1, 1, 2'b01, 1, 1, 0);
    for (int i = 0; i < 4; i++) add(0, 2'b11, 1, 1, 1, 2'b10, 1, 0, 1);
    for (int i = 0; i < 4; i++) add(0, 2'b11, 1, 1, 1, 2'b01, 1, 1, 0);
    add(1, 2'b11, 1, 1, 1, 2'b10, 0, 0, 0);
    // src0 valid stalls for 3 cycles after beat 2; grant is held.
    add(0, 2'b11, 1, 1, 1, 2'b00, 0, 0, 0);
    for (int i = 0; i < 2; i++) add(0, 2'b11, 1, 1, 1, 2'b01, 1, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 2'b11, 0, 1, 1, 2'b01, 0, 1, 0);
    for (int i = 0; i < 2; i++) add(0, 2'b11, 1, 1, 1, 2'b01, 1, 1, 0);
    add(0, 2'b11, 1, 1, 1, 2'b10, 1, 0, 1);
    add(1, 2'b11, 1, 1, 1, 2'b10, 0, 0, 0);
    // Enable=10: only src1; enable dropped after beat 1 still finishes burst.
    add(0, 2'b10, 1, 1, 1, 2'b00, 0, 0, 0);
    add(0, 2'b10, 1, 1, 1, 2'b10, 1, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 2'b00, 1, 1, 1, 2'b10, 1, 0, 1);
    for (int i = 0; i < 2; i++) add(0, 2'b00, 1, 1, 1, 2'b00, 0, 0, 0);
    // Ready toggling: beats only on ready-high cycles.
    add(0, 2'b11, 1, 0, 1, 2'b00, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      add(0, 2'b11, 1, 0, 1, 2'b01, 1, 1, 0);
      if (k < 3) add(0, 2'b11, 1, 0, 0, 2'b01, 1, 0, 0);
    end
    add(0, 2'b11, 1, 0, 0, 2'b01, 1, 0, 0);
    // Reset after beat 2; afterwards src0 wins again with both requesting.
    for (int i = 0; i < 2; i++) add(0, 2'b11, 1, 1, 1, 2'b01, 1, 1, 0);
    add(1, 2'b11, 1, 1, 1, 2'b01, 0, 0, 0);
    add(0, 2'b11, 1, 1, 1, 2'b00, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 2'b11, 1, 1, 1, 2'b01, 1, 1, 0);
    add(0, 2'b11, 1, 1, 1, 2'b10, 1, 0, 1);

    // Reset: handshake outputs forced low while reset is high.
    @(posedge clk); #1;
    en = 2'b11; v0 = 1'b1; v1 = 1'b1; rdy = 1'b1;
    @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_ready0", r0, 0);
    chk("rst_ready1", r1, 0);
    @(posedge clk); #1;
    reset = 1'b0; v0 = 1'b0; v1 = 1'b0;
    @(negedge clk);
    chk("rst_grant", grant, 2'b00);
    chk("rst_beats0", b0, 0);
    chk("rst_beats1", b1, 0);

    foreach (vecs[i]) begin
      vec_t vr;
      vr = vecs[i];
      @(posedge clk); #1;
      reset = vr.rst; en = vr.en; v0 = vr.v0; v1 = vr.v1; rdy = vr.rdy;
      d0 = {32'hA0A0_0000, 32'(i)};
      d1 = {32'hB1B1_0000, 32'(i)};
      if (!vr.rst && vr.ev && vr.rdy) sb.push_back(vr.eg == 2'b01 ? d0 : d1);
      @(negedge clk);
      chk($sformatf("grant[%0d]", i), grant, vr.eg);
      chk($sformatf("valid[%0d]", i), valid, vr.ev);
      chk($sformatf("ready0[%0d]", i), r0, vr.er0);
      chk($sformatf("ready1[%0d]", i), r1, vr.er1);
      chk($sformatf("beats0[%0d]", i), b0, STATS ? 32'(eb0) : 32'd0);
      chk($sformatf("beats1[%0d]", i), b1, STATS ? 32'(eb1) : 32'd0);
      if (valid && rdy) begin
        if (sb.size() == 0) chk($sformatf("sb_unexpected[%0d]", i), 1, 0);
        else chk($sformatf("data[%0d]", i), dout, sb.pop_front());
      end
      if (vr.rst) begin
        eb0 = 0;
        eb1 = 0;
      end else if (vr.ev && vr.rdy) begin
        if (vr.eg == 2'b01) eb0++;
        else eb1++;
      end
    end
    chk("sb_drain", sb.size(), 0);

    // Lone src1 request after reset must be granted within a bounded wait.
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; en = 2'b11; v0 = 1'b0; v1 = 1'b1; rdy = 1'b1;
    d1 = 64'h1234_5678_9ABC_DEF0;
    begin
      bit found;
      found = 1'b0;
      for (int n = 0; n < 10 && !found; n++) begin
        @(negedge clk);
        if (grant == 2'b10) found = 1'b1;
      end
      chk("grant1_wait", found, 1);
      chk("grant1_data", dout, 64'h1234_5678_9ABC_DEF0);
      chk("grant1_ready", r1, 1);
      chk("grant1_ready0", r0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
